// File: rtl/lm80c_sio_lite.sv
// lm80c_sio_lite
// Minimal Z80-bus serial port: one transmit holding register feeding an 8N1
// shifter, an 8N1 receiver with glitch rejection, and a 4-entry receive FIFO.
//
// Ports
//   sys_clock     system clock, all logic on its rising edge
//   RESET         synchronous, active-high reset
//   cs            chip select (I/O address decoded to the SIO range)
//   a0            register select: 0 = data, 1 = control/status
//   iorq_n        Z80 I/O request strobe, active-low
//   rd_n, wr_n    Z80 read / write strobes, active-low
//   din[7:0]      CPU write data
//   dout[7:0]     CPU read data, registered, held between reads
//   int_n         level interrupt request, active-low, registered
//   rxd           asynchronous serial input, idle high
//   txd           serial output, idle high
//
// Status byte: {0, FE, OVR, 0, 0, TXE, INTP, RXA}
// Control byte: bit0 RX int enable, bit1 TX int enable, bit7 clears OVR/FE
module lm80c_sio_lite #(
    parameter int DIVISOR = 16
) (
    input  logic       sys_clock,
    input  logic       RESET,
    input  logic       cs,
    input  logic       a0,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       int_n,
    input  logic       rxd,
    output logic       txd
);

    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] BIT_END  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIVISOR / 2 - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Bus strobe edge detection: a bus cycle may last many clocks, but only
    // its first clock produces an access event.
    // ------------------------------------------------------------------
    logic rdAct, wrAct, rdEvt, wrEvt;
    logic rdPrev_q, wrPrev_q;

    assign rdAct = cs & ~iorq_n & ~rd_n;
    assign wrAct = cs & ~iorq_n & ~wr_n;
    assign rdEvt = rdAct & ~rdPrev_q;
    assign wrEvt = wrAct & ~wrPrev_q;

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            rdPrev_q <= 1'b0;
            wrPrev_q <= 1'b0;
        end else begin
            rdPrev_q <= rdAct;
            wrPrev_q <= wrAct;
        end
    end

    // ------------------------------------------------------------------
    // Receive synchroniser plus a delayed copy for start-edge detection.
    // ------------------------------------------------------------------
    logic rxS1_q, rxS2_q, rxPrev_q;

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            rxS1_q   <= 1'b1;
            rxS2_q   <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxS1_q   <= rxd;
            rxS2_q   <= rxS1_q;
            rxPrev_q <= rxS2_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM. The start bit is re-checked at its midpoint so short
    // low glitches are ignored; every later sample is one bit time on.
    // ------------------------------------------------------------------
    logic [1:0]    rxState_q, rxState_d;
    logic [CW-1:0] rxCnt_q, rxCnt_d;
    logic [2:0]    rxBit_q, rxBit_d;
    logic [7:0]    rxShift_q, rxShift_d;
    logic          rxPush, rxFrameErr;

    always_comb begin
        rxState_d  = rxState_q;
        rxCnt_d    = rxCnt_q;
        rxBit_d    = rxBit_q;
        rxShift_d  = rxShift_q;
        rxPush     = 1'b0;
        rxFrameErr = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                if (rxPrev_q & ~rxS2_q) begin
                    rxState_d = RX_START;
                    rxCnt_d   = '0;
                end
            end
            RX_START: begin
                if (rxCnt_q == HALF_END) begin
                    rxCnt_d = '0;
                    rxBit_d = 3'd0;
                    rxState_d = rxS2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rxCnt_q == BIT_END) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxS2_q, rxShift_q[7:1]};
                    if (rxBit_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end else begin
                        rxBit_d = rxBit_q + 3'd1;
                    end
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rxCnt_q == BIT_END) begin
                    rxCnt_d    = '0;
                    rxState_d  = RX_IDLE;
                    rxPush     = rxS2_q;
                    rxFrameErr = ~rxS2_q;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxBit_q   <= 3'd0;
            rxShift_q <= 8'h00;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxBit_q   <= rxBit_d;
            rxShift_q <= rxShift_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO. A pop frees a slot in the same cycle, so a push that
    // meets a full FIFO still succeeds when a read happens at once.
    // ------------------------------------------------------------------
    logic [7:0] fifoMem_q [4];
    logic [1:0] wrPtr_q, rdPtr_q;
    logic [2:0] count_q;
    logic       fifoEmpty, fifoFull, dataRd, doPop, doPush, ovrSet;

    assign fifoEmpty = (count_q == 3'd0);
    assign fifoFull  = (count_q == 3'd4);
    assign dataRd    = rdEvt & ~a0;
    assign doPop     = dataRd & ~fifoEmpty;
    assign doPush    = rxPush & (~fifoFull | doPop);
    assign ovrSet    = rxPush & fifoFull & ~doPop;

    always_ff @(posedge sys_clock) begin
        if (!RESET && doPush) begin
            fifoMem_q[wrPtr_q] <= rxShift_q;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            wrPtr_q <= 2'd0;
            rdPtr_q <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 2'd1;
            if (doPop)  rdPtr_q <= rdPtr_q + 2'd1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter FSM. The holding register is moved into the shifter
    // from idle, or straight from the end of a stop bit so consecutive
    // bytes leave without an idle gap.
    // ------------------------------------------------------------------
    logic [1:0]    txState_q, txState_d;
    logic [CW-1:0] txCnt_q, txCnt_d;
    logic [2:0]    txBit_q, txBit_d;
    logic [7:0]    txShift_q, txShift_d;
    logic [7:0]    hold_q, hold_d;
    logic          txe_q, txe_d;
    logic          txd_q, txd_d;

    always_comb begin
        txState_d = txState_q;
        txCnt_d   = txCnt_q;
        txBit_d   = txBit_q;
        txShift_d = txShift_q;
        hold_d    = hold_q;
        txe_d     = txe_q;
        txd_d     = txd_q;
        if (wrEvt & ~a0 & txe_q) begin
            hold_d = din;
            txe_d  = 1'b0;
        end
        case (txState_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (~txe_q) begin
                    txShift_d = hold_q;
                    txe_d     = 1'b1;
                    txState_d = TX_START;
                    txCnt_d   = '0;
                    txd_d     = 1'b0;
                end
            end
            TX_START: begin
                if (txCnt_q == BIT_END) begin
                    txCnt_d   = '0;
                    txBit_d   = 3'd0;
                    txState_d = TX_DATA;
                    txd_d     = txShift_q[0];
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (txCnt_q == BIT_END) begin
                    txCnt_d = '0;
                    if (txBit_q == 3'd7) begin
                        txState_d = TX_STOP;
                        txd_d     = 1'b1;
                    end else begin
                        txBit_d   = txBit_q + 3'd1;
                        txShift_d = {1'b0, txShift_q[7:1]};
                        txd_d     = txShift_q[1];
                    end
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (txCnt_q == BIT_END) begin
                    txCnt_d = '0;
                    if (~txe_q) begin
                        txShift_d = hold_q;
                        txe_d     = 1'b1;
                        txState_d = TX_START;
                        txd_d     = 1'b0;
                    end else begin
                        txState_d = TX_IDLE;
                    end
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            default: txState_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= 3'd0;
            txShift_q <= 8'h00;
            hold_q    <= 8'h00;
            txe_q     <= 1'b1;
            txd_q     <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txCnt_q   <= txCnt_d;
            txBit_q   <= txBit_d;
            txShift_q <= txShift_d;
            hold_q    <= hold_d;
            txe_q     <= txe_d;
            txd_q     <= txd_d;
        end
    end

    // ------------------------------------------------------------------
    // Control, sticky error flags, read data and interrupt. Error flags
    // set in the same cycle as a clearing write stay set.
    // ------------------------------------------------------------------
    logic       rxie_q, txie_q, ovr_q, fe_q, intN_q;
    logic [7:0] dout_q;
    logic       intCause;
    logic [7:0] statusByte;

    assign intCause   = (rxie_q & ~fifoEmpty) | (txie_q & txe_q);
    assign statusByte = {1'b0, fe_q, ovr_q, 2'b00, txe_q, intCause, ~fifoEmpty};

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            rxie_q <= 1'b0;
            txie_q <= 1'b0;
            ovr_q  <= 1'b0;
            fe_q   <= 1'b0;
            dout_q <= 8'h00;
            intN_q <= 1'b1;
        end else begin
            if (wrEvt & a0) begin
                rxie_q <= din[0];
                txie_q <= din[1];
                if (din[7]) begin
                    ovr_q <= 1'b0;
                    fe_q  <= 1'b0;
                end
            end
            if (ovrSet)     ovr_q <= 1'b1;
            if (rxFrameErr) fe_q  <= 1'b1;
            if (rdEvt) begin
                if (a0)             dout_q <= statusByte;
                else if (fifoEmpty) dout_q <= 8'h00;
                else                dout_q <= fifoMem_q[rdPtr_q];
            end
            intN_q <= ~intCause;
        end
    end

    assign dout  = dout_q;
    assign int_n = intN_q;
    assign txd   = txd_q;

endmodule

// File: tb/tb_lm80c_sio_lite.sv
// tb_lm80c_sio_lite
// Self-checking bench for lm80c_sio_lite. A behavioural model (byte queue,
// flag bits) predicts every CPU-visible value; serial traffic is produced
// and decoded at bit level by the bench.
module tb_lm80c_sio_lite;

    localparam int DIV = 16;

    logic       sysClock = 1'b0;
    logic       reset;
    logic       cs, a0, iorqN, rdN, wrN;
    logic [7:0] din;
    logic [7:0] dout;
    logic       intN;
    logic       rxd;
    logic       txd;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] rxModel[$];
    bit         ovrM, feM, rxieM, txieM;

    lm80c_sio_lite #(.DIVISOR(DIV)) dut (
        .sys_clock(sysClock),
        .RESET(reset),
        .cs(cs),
        .a0(a0),
        .iorq_n(iorqN),
        .rd_n(rdN),
        .wr_n(wrN),
        .din(din),
        .dout(dout),
        .int_n(intN),
        .rxd(rxd),
        .txd(txd)
    );

    // Free-running clock, 10 time units per cycle
    always #5 sysClock = ~sysClock;

    // Watchdog so a stuck run still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One Z80 I/O bus cycle, strobe held for 'hold' clocks
    task automatic applyStimulus(input bit isWrite, input bit addr, input logic [7:0] wdata,
                                 input int hold, output logic [7:0] rdata);
        @(negedge sysClock);
        cs    = 1'b1;
        iorqN = 1'b0;
        a0    = addr;
        din   = wdata;
        if (isWrite) wrN = 1'b0;
        else         rdN = 1'b0;
        repeat (hold) @(negedge sysClock);
        cs    = 1'b0;
        iorqN = 1'b1;
        rdN   = 1'b1;
        wrN   = 1'b1;
        @(negedge sysClock);
        rdata = dout;
    endtask

    function automatic bit modelIntp();
        return (rxieM && rxModel.size() != 0) || txieM;
    endfunction

    // Status as seen while the transmitter is idle (TXE = 1)
    function automatic logic [7:0] modelStatus();
        logic rxa;
        rxa = (rxModel.size() != 0);
        return {1'b0, feM, ovrM, 2'b00, 1'b1, modelIntp(), rxa};
    endfunction

    function automatic void modelReset();
        rxModel.delete();
        ovrM = 0; feM = 0; rxieM = 0; txieM = 0;
    endfunction

    function automatic void modelRxFrame(input logic [7:0] data, input bit stopOk);
        if (!stopOk)                 feM = 1;
        else if (rxModel.size() < 4) rxModel.push_back(data);
        else                         ovrM = 1;
    endfunction

    function automatic void modelCtrl(input logic [7:0] v);
        rxieM = v[0];
        txieM = v[1];
        if (v[7]) begin
            ovrM = 0;
            feM  = 0;
        end
    endfunction

    task automatic checkStatus(input string tag);
        logic [7:0] r;
        applyStimulus(1'b0, 1'b1, 8'h00, 1, r);
        checkOutput(tag, r, modelStatus());
        checkOutput({tag, "_intn"}, intN, !modelIntp());
    endtask

    task automatic readData(input string tag, input int hold);
        logic [7:0] r, expd;
        applyStimulus(1'b0, 1'b0, 8'h00, hold, r);
        expd = (rxModel.size() != 0) ? rxModel.pop_front() : 8'h00;
        checkOutput(tag, r, expd);
    endtask

    task automatic writeCtrl(input logic [7:0] v);
        logic [7:0] r;
        applyStimulus(1'b1, 1'b1, v, 1, r);
        modelCtrl(v);
    endtask

    // Drive one 8N1 frame on rxd, LSB first
    task automatic sendRxByte(input logic [7:0] data, input bit stopBit);
        @(negedge sysClock);
        rxd = 1'b0;
        repeat (DIV) @(negedge sysClock);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (DIV) @(negedge sysClock);
        end
        rxd = stopBit;
        repeat (DIV) @(negedge sysClock);
        rxd = 1'b1;
        repeat (2) @(negedge sysClock);
    endtask

    // Decode one frame from txd by sampling bit midpoints
    task automatic decodeTx(input string tag, output logic [7:0] data);
        int waitCnt;
        waitCnt = 0;
        while (txd !== 1'b0 && waitCnt < 2000) begin
            @(negedge sysClock);
            waitCnt++;
        end
        checkOutput({tag, "_start"}, txd, 1'b0);
        repeat (DIV / 2) @(negedge sysClock);
        checkOutput({tag, "_startmid"}, txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge sysClock);
            data[i] = txd;
        end
        repeat (DIV) @(negedge sysClock);
        checkOutput({tag, "_stop"}, txd, 1'b1);
    endtask

    // Exact run lengths of a 0x55 frame: nine alternating runs of DIV cycles
    task automatic measureRuns55();
        int waitCnt, runLen;
        logic lvl;
        waitCnt = 0;
        while (txd !== 1'b0 && waitCnt < 2000) begin
            @(negedge sysClock);
            waitCnt++;
        end
        checkOutput("tx55_start", txd, 1'b0);
        for (int r = 0; r < 9; r++) begin
            lvl    = r[0];
            runLen = 0;
            while (txd === lvl && runLen < 100) begin
                runLen++;
                @(negedge sysClock);
            end
            checkOutput($sformatf("tx55_run%0d", r), runLen, DIV);
        end
        runLen = 0;
        while (txd === 1'b1 && runLen < 40) begin
            runLen++;
            @(negedge sysClock);
        end
        checkOutput("tx55_stopLen", runLen >= DIV, 1'b1);
    endtask

    initial begin
        logic [7:0] r, d;
        int gap;

        reset = 1'b1;
        cs = 1'b0; a0 = 1'b0; iorqN = 1'b1; rdN = 1'b1; wrN = 1'b1;
        din = 8'h00; rxd = 1'b1;
        modelReset();
        repeat (4) @(negedge sysClock);
        checkOutput("reset_dout", dout, 8'h00);
        checkOutput("reset_intn", intN, 1'b1);
        checkOutput("reset_txd", txd, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge sysClock);
        checkStatus("reset_status");

        $display("[TB] transmit 0x55 timing");
        fork
            begin
                applyStimulus(1'b1, 1'b0, 8'h55, 1, r);
                applyStimulus(1'b0, 1'b1, 8'h00, 1, r);
                checkOutput("tx55_txeAfterLoad", r[2], 1'b1);
            end
            measureRuns55();
        join

        $display("[TB] receive 0xA3");
        sendRxByte(8'hA3, 1'b1);
        modelRxFrame(8'hA3, 1'b1);
        checkStatus("rxA3_status1");
        readData("rxA3_data", 1);
        checkStatus("rxA3_status2");

        $display("[TB] overrun");
        for (int i = 1; i <= 5; i++) begin
            sendRxByte(8'(i), 1'b1);
            modelRxFrame(8'(i), 1'b1);
        end
        checkStatus("ovr_status");
        for (int i = 0; i < 4; i++) readData($sformatf("ovr_data%0d", i), 1);
        writeCtrl(8'h80);
        checkStatus("ovr_cleared");

        $display("[TB] framing error and glitch");
        sendRxByte(8'h6E, 1'b0);
        modelRxFrame(8'h6E, 1'b0);
        checkStatus("fe_status");
        writeCtrl(8'h80);
        @(negedge sysClock);
        rxd = 1'b0;
        repeat (4) @(negedge sysClock);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge sysClock);
        checkStatus("glitch_status");

        $display("[TB] transmit interrupt and back-to-back bytes");
        writeCtrl(8'h02);
        checkOutput("int_txEmpty", intN, 1'b0);
        fork
            begin
                applyStimulus(1'b1, 1'b0, 8'h3C, 1, r);
                applyStimulus(1'b1, 1'b0, 8'hC5, 1, r);
                checkOutput("int_holdFull", intN, 1'b1);
                applyStimulus(1'b0, 1'b1, 8'h00, 1, r);
                checkOutput("status_holdFull", r, 8'h00);
            end
            begin
                decodeTx("tx1", d);
                checkOutput("tx1_data", d, 8'h3C);
            end
        join
        gap = 0;
        while (txd !== 1'b0 && gap < 100) begin
            @(negedge sysClock);
            gap++;
        end
        checkOutput("tx_noGap", gap, DIV / 2);
        decodeTx("tx2", d);
        checkOutput("tx2_data", d, 8'hC5);
        checkOutput("int_afterTransfer", intN, 1'b0);
        writeCtrl(8'h00);
        checkOutput("int_disabled", intN, 1'b1);

        $display("[TB] long read strobe");
        sendRxByte(8'h91, 1'b1);
        modelRxFrame(8'h91, 1'b1);
        sendRxByte(8'h2B, 1'b1);
        modelRxFrame(8'h2B, 1'b1);
        readData("longRead_data", 20);
        checkStatus("longRead_status");
        readData("longRead_second", 1);

        $display("[TB] reset during transmit");
        writeCtrl(8'h03);
        applyStimulus(1'b1, 1'b0, 8'h00, 1, r);
        repeat (40) @(negedge sysClock);
        checkOutput("txMid_low", txd, 1'b0);
        reset = 1'b1;
        @(negedge sysClock);
        checkOutput("txReset_txd", txd, 1'b1);
        checkOutput("txReset_intn", intN, 1'b1);
        reset = 1'b0;
        modelReset();
        repeat (3 * DIV) @(negedge sysClock);
        checkOutput("txReset_idle", txd, 1'b1);
        checkStatus("txReset_status");

        $display("[TB] reset during receive");
        fork
            sendRxByte(8'h5A, 1'b1);
            begin
                repeat (50) @(negedge sysClock);
                reset = 1'b1;
                repeat (130) @(negedge sysClock);
                reset = 1'b0;
            end
        join
        repeat (2 * DIV) @(negedge sysClock);
        checkStatus("rxReset_status");
        readData("rxReset_data", 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 30; i++) begin
            int op;
            logic [7:0] v;
            op = $urandom_range(0, 5);
            v  = 8'($urandom_range(0, 255));
            case (op)
                0, 1: begin
                    sendRxByte(v, 1'b1);
                    modelRxFrame(v, 1'b1);
                end
                2: begin
                    sendRxByte(v, 1'b0);
                    modelRxFrame(v, 1'b0);
                end
                3: readData($sformatf("rnd%0d_data", i), $urandom_range(1, 6));
                4: checkStatus($sformatf("rnd%0d_status", i));
                default: writeCtrl(v & 8'h83);
            endcase
            repeat ($urandom_range(0, 4)) @(negedge sysClock);
            checkOutput($sformatf("rnd%0d_intn", i), intN, !modelIntp());
        end
        checkStatus("rnd_finalStatus");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
